mult_div_unit: RTL and testbench

//  Iterative multiply/divide unit for the MIPS execute stage, beside the ALU.
//  It takes the same a/b operand buses from the register-file read ports and

---
 rtl/mdu_pkg.sv | 20 ++
 rtl/mdu_step.sv | 42 ++++
 rtl/mult_div_unit.sv | 115 +++++++++++
 tb/tb_mult_div_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: op codes, FSM states
// and the default datapath width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration on the {acc,q} pair: shift-add for multiply,
// restoring shift-subtract for divide. Purely combinational.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] operand,
  input  logic             is_div,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum      = {1'b0, acc} + {1'b0, operand};
    shifted  = {acc, q[WIDTH-1]};
    diff     = shifted - {1'b0, operand};
    acc_next = acc;
    q_next   = q;
    if (is_div) begin
      // diff[WIDTH] is the borrow: partial remainder is below the divisor
      if (!diff[WIDTH]) begin
        acc_next = diff[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = shifted[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b0};
      end
    end else if (q[0]) begin
      {acc_next, q_next} = {sum, q[WIDTH-1:1]};
    end else begin
      {acc_next, q_next} = {1'b0, acc, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative mult/multu/div/divu unit holding the architectural HI/LO registers.
// Operands are made unsigned at accept; signs are reapplied in the FIX state.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e         state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               is_div, neg_q, neg_r, div0;
  logic [WIDTH-1:0]   acc, q, opnd;
  logic [WIDTH-1:0]   acc_step, q_step;
  logic               is_signed, last_step, accept;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign is_signed = ~op[0];
  // -x of the most-negative value is the same bit pattern, read as unsigned
  assign abs_a     = (is_signed && a[WIDTH-1]) ? -a : a;
  assign abs_b     = (is_signed && b[WIDTH-1]) ? -b : b;
  assign last_step = (cnt == CNT_W'(WIDTH - 1));
  assign accept    = (state == S_IDLE) && start;
  assign busy      = (state != S_IDLE);
  assign prod      = {acc, q};
  assign prod_fix  = neg_q ? -prod : prod;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .q        (q),
    .operand  (opnd),
    .is_div   (is_div),
    .acc_next (acc_step),
    .q_next   (q_step)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_step) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == S_FIX);
      cnt   <= (state == S_RUN) ? cnt + CNT_W'(1) : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      q      <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
    end else if (accept) begin
      is_div <= op[1];
      neg_q  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r  <= is_signed & a[WIDTH-1];
      div0   <= (b == '0);
      acc    <= '0;
      q      <= op[1] ? abs_a : abs_b;
      opnd   <= op[1] ? abs_b : abs_a;
    end else if (state == S_RUN) begin
      acc <= acc_step;
      q   <= q_step;
    end
  end

  // Divide by zero leaves acc=|a|, so the remainder sign fix restores HI=a
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == S_FIX) begin
      if (is_div) begin
        hi <= neg_r ? -acc : acc;
        lo <= div0 ? '1 : (neg_q ? -q : q);
      end else begin
        hi <= prod_fix[2*WIDTH-1:WIDTH];
        lo <= prod_fix[WIDTH-1:0];
      end
    end else if (state == S_IDLE && !start) begin
      if (hi_we) hi <= a;
      if (lo_we) lo <= a;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized checks of mult_div_unit against an arithmetic
// reference model built on 64-bit integer multiply/divide.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] a, b, hi, lo;
  logic         busy, done;
  logic [W-1:0] exp_hi, exp_lo, saved;
  int           tests = 0;
  int           fails = 0;
  int           done_seen;

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic void model(input logic [1:0] m_op, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] eh, output logic [W-1:0] el);
    longint          sx, sy, sp;
    longint unsigned ux, uy, up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (m_op)
      MDU_MULT: begin
        sp = sx * sy;
        {eh, el} = sp;
      end
      MDU_MULTU: begin
        up = ux * uy;
        {eh, el} = up;
      end
      MDU_DIV: begin
        if (y == '0) begin
          eh = x;
          el = '1;
        end else begin
          el = W'(sx / sy);
          eh = W'(sx % sy);
        end
      end
      default: begin
        if (y == '0) begin
          eh = x;
          el = '1;
        end else begin
          el = W'(ux / uy);
          eh = W'(ux % uy);
        end
      end
    endcase
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 32'h8000_0000;
      2: return '1;
      3: return 32'h0000_0001;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called #1 after a rising edge; the start is accepted at the next edge
  task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    model(o, x, y, exp_hi, exp_lo);
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom);
    a = $urandom;
    b = $urandom;
    check("busy_after_accept", W'(busy), W'(1));
  endtask

  task automatic finish_op(input string tag, input bit inject);
    int n = 0;
    int early = 0;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (busy && done) early++;
      a = $urandom;
      b = $urandom;
      start = 1'b0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      if (inject && n == 3) begin
        hi_we = 1'b1;
        lo_we = 1'b1;
        a = 32'h1234_5678;
      end
      if (inject && n == 10) begin
        start = 1'b1;
        op = MDU_DIVU;
      end
    end
    check({tag, "_latency"}, W'(n), W'(33));
    check({tag, "_early_done"}, W'(early), W'(0));
    check({tag, "_done"}, W'(done), W'(1));
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    op = MDU_MULT;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    launch(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("multu_max", 1'b0);
    check("multu_max_hi_const", hi, 32'hFFFF_FFFE);
    check("multu_max_lo_const", lo, 32'h0000_0001);
    @(posedge clk); #1;
    check("done_single_pulse", W'(done), W'(0));

    launch(MDU_MULT, 32'hFFFF_FFFD, 32'h0000_0007);
    finish_op("mult_neg", 1'b0);
    check("mult_neg_lo_const", lo, 32'hFFFF_FFEB);

    launch(MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    finish_op("div_neg", 1'b0);
    check("div_neg_lo_const", lo, 32'hFFFF_FFFD);
    check("div_neg_hi_const", hi, 32'hFFFF_FFFF);

    launch(MDU_DIVU, 32'h0000_0064, 32'h0000_0000);
    finish_op("divu_zero", 1'b0);
    check("divu_zero_hi_const", hi, 32'h0000_0064);

    launch(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("div_ovf", 1'b0);
    check("div_ovf_lo_const", lo, 32'h8000_0000);
    check("div_ovf_hi_const", hi, 32'h0000_0000);
    launch(MDU_DIV, 32'h0000_3039, 32'hFFFF_FFEF);
    finish_op("b2b_div", 1'b0);

    launch(MDU_DIV, 32'hFFFF_FF00, 32'h0000_0000);
    finish_op("div_neg_zero", 1'b0);

    launch(MDU_MULT, 32'h8000_0000, 32'h8000_0000);
    finish_op("mult_minmin", 1'b0);

    launch(MDU_MULT, 32'h0000_1234, 32'hFFFF_FF10);
    finish_op("ignore_busy", 1'b1);

    saved = lo;
    hi_we = 1'b1;
    a = 32'h1234_5678;
    @(posedge clk); #1;
    hi_we = 1'b0;
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_lo_kept", lo, saved);

    hi_we = 1'b1;
    lo_we = 1'b1;
    a = 32'hCAFE_F00D;
    @(posedge clk); #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    check("mthilo_hi", hi, 32'hCAFE_F00D);
    check("mthilo_lo", lo, 32'hCAFE_F00D);

    hi_we = 1'b1;
    lo_we = 1'b1;
    launch(MDU_MULTU, 32'h0000_0003, 32'h0000_0005);
    hi_we = 1'b0;
    lo_we = 1'b0;
    finish_op("start_prio", 1'b0);

    launch(MDU_MULT, 32'h7654_3210, 32'h8765_4321);
    repeat (9) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    check("abort_busy", W'(busy), W'(0));
    check("abort_hi", hi, '0);
    check("abort_lo", lo, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    check("abort_no_done", W'(done_seen), W'(0));
    launch(MDU_DIVU, 32'hDEAD_BEEF, 32'h0000_1001);
    finish_op("after_abort", 1'b0);

    for (int i = 0; i < 16; i++) begin
      launch(2'($urandom), pick(), pick());
      finish_op($sformatf("rand%0d", i), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
